load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have clock and reset: one clock; reset is synchronous and active-high.
REQ-002 SHALL have i_clk, input, 1, rising-edge clock.
REQ-003 SHALL have i_rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have i_valid, input, 1, execute stage presents a memory op.
REQ-005 SHALL have i_mem_write, input, 1, 1 = store, 0 = load (decoder mem_write).
REQ-006 SHALL have i_funct3, input, 3, access size and sign: [1:0] 00 byte, 01 half, 1x word; [2] 1 = zero-extend.
REQ-007 SHALL have i_addr, input, 32, effective byte address (ALU result).
REQ-008 SHALL have i_wdata, input, 32, store data (rs2).
REQ-009 SHALL have o_busy, output, 1, pipeline stall request.
REQ-010 SHALL have o_done, output, 1, one-cycle completion pulse.
REQ-011 SHALL have o_rdata, output, 32, aligned, extended load result.
REQ-012 SHALL have o_misaligned, output, 1, misaligned-access flag.
REQ-013 SHALL have o_bus_req, o_bus_wen, o_bus_addr[31:0], o_bus_wmask[3:0], o_bus_wdata[31:0] as outputs, and i_bus_ready, i_bus_rvalid, i_bus_rdata[31:0] as inputs.

Function
REQ-014 SHALL implement FSM states IDLE, REQ, WAIT, DONE.
REQ-015 IDLE: when i_valid=1 and o_done=0, SHALL latch all operands and go to REQ; otherwise it SHALL stay in IDLE.
REQ-016 REQ: o_bus_req=1; when i_bus_ready=1, a store SHALL go to DONE and a load SHALL go to WAIT.
REQ-017 WAIT: when i_bus_rvalid=1, SHALL capture the formatted i_bus_rdata into o_rdata and go to DONE.
REQ-018 DONE: o_done=1 for exactly one cycle, then return to IDLE.
REQ-019 o_busy SHALL equal (state!=IDLE && state!=DONE) || (state==IDLE && i_valid), combinationally.
REQ-020 Minimum latency from accept to o_done SHALL be 3 cycles for a store and 4 cycles for a load.
REQ-021 o_bus_addr SHALL be {addr[31:2],2'b00}, and o_bus_wen SHALL equal the latched i_mem_write.
REQ-022 All bus outputs SHALL hold stable while o_bus_req=1 until i_bus_ready=1.
REQ-023 Store byte access: wdata SHALL be {4{wdata[7:0]}} and wmask SHALL be 1<<addr[1:0].
REQ-024 Store half access: wdata SHALL be {2{wdata[15:0]}} and wmask SHALL be 4'b0011 when addr[1]=0, else 4'b1100.
REQ-025 Store word access: wmask SHALL be 4'b1111.
REQ-026 Loads SHALL drive wmask=0.
REQ-027 Loads SHALL select the byte/half by addr[1:0]/addr[1], then sign-extend when funct3[2]=0, else zero-extend.
REQ-028 o_rdata SHALL hold its value until the next load completes, and SHALL be unchanged by stores.
REQ-029 i_bus_rvalid outside WAIT and i_bus_ready outside REQ SHALL be ignored.

Reset
REQ-030 On reset, the unit SHALL enter IDLE with o_bus_req, o_done, o_misaligned, o_bus_wen and o_bus_wmask = 0, and o_rdata = 0.
REQ-031 Reset asserted mid-transaction SHALL abandon the transaction, and a late rvalid SHALL be ignored.

Configuration
REQ-032 Macro LSU_MISALIGN_TRAP_EN, when defined, SHALL detect half accesses with addr[0]=1 and word accesses with addr[1:0]!=0, skip REQ/WAIT, go IDLE->DONE with o_misaligned=1 and o_rdata=0, and issue no bus request.
REQ-033 Without LSU_MISALIGN_TRAP_EN, o_misaligned SHALL be tied 0, halves SHALL ignore addr[0], and words SHALL ignore addr[1:0].

Verification
REQ-034 SW addr=0x100, wdata=0xDEADBEEF, ready on first REQ cycle -> bus addr 0x100, wmask 1111, o_done 3 cycles after accept.
REQ-035 SB addr=0x103, wdata=0x000000A5 -> wdata 0xA5A5A5A5, wmask 1000.
REQ-036 LB addr=0x201, rdata=0x0000_80_00 (byte1=0x80) -> o_rdata 0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-037 LH addr=0x302, ready stalled 3 cycles, rvalid 2 cycles later -> request held stable, o_rdata = sign-extended rdata[31:16], o_busy high until DONE.
REQ-038 Reset asserted in WAIT followed by an rvalid pulse -> IDLE, o_bus_req=0, o_done never asserts.
REQ-039 With LSU_MISALIGN_TRAP_EN, LW addr=0x102 -> no o_bus_req, o_done and o_misaligned high 2 cycles after accept.

Source files
------------

// File: rtl/lsu_bus_if.sv
// Load/store unit data-bus interface.
// The master drives the request side; the slave returns ready/rvalid/rdata.
interface lsu_bus_if;
  logic        o_bus_req;
  logic        o_bus_wen;
  logic [31:0] o_bus_addr;
  logic [3:0]  o_bus_wmask;
  logic [31:0] o_bus_wdata;
  logic        i_bus_ready;
  logic        i_bus_rvalid;
  logic [31:0] i_bus_rdata;

  modport master (
    output o_bus_req,
    output o_bus_wen,
    output o_bus_addr,
    output o_bus_wmask,
    output o_bus_wdata,
    input  i_bus_ready,
    input  i_bus_rvalid,
    input  i_bus_rdata
  );

  modport slave (
    input  o_bus_req,
    input  o_bus_wen,
    input  o_bus_addr,
    input  o_bus_wmask,
    input  o_bus_wdata,
    output i_bus_ready,
    output i_bus_rvalid,
    output i_bus_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: IDLE/REQ/WAIT/DONE bus sequencer with lane steering.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module load_store_unit (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_mem_write,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_misaligned,
  lsu_bus_if.master   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  state_t      r_state;
  logic        r_req;
  logic        r_wen;
  logic [31:0] r_addr;
  logic [3:0]  r_wmask;
  logic [31:0] r_wdata;
  logic [2:0]  r_f3;
  logic [1:0]  r_off;
  logic        r_trap;
  logic        r_done;
  logic        r_mis;
  logic [31:0] r_rdata;

  logic        w_word;
  logic        w_half;
  logic        w_mis;
  logic [3:0]  w_wmask;
  logic [31:0] w_wdata;
  logic [7:0]  w_lb;
  logic [15:0] w_lh;
  logic        w_sx;
  logic [31:0] w_load;

  assign w_word = i_funct3[1];
  assign w_half = ~i_funct3[1] & i_funct3[0];

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_mis = (w_half & i_addr[0]) |
                 (w_word & (|i_addr[1:0]));
`else
  assign w_mis = 1'b0;
`endif

  always_comb begin
    w_wmask = 4'b0001 << i_addr[1:0];
    w_wdata = {4{i_wdata[7:0]}};
    unique case (1'b1)
      w_word: begin
        w_wmask = 4'b1111;
        w_wdata = i_wdata;
      end
      w_half: begin
        w_wmask = i_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{i_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // lane select from the latched offset, then extend
  always_comb begin
    w_lh = r_off[1] ? bus.i_bus_rdata[31:16]
                    : bus.i_bus_rdata[15:0];
    unique case (r_off)
      2'd0: w_lb = bus.i_bus_rdata[7:0];
      2'd1: w_lb = bus.i_bus_rdata[15:8];
      2'd2: w_lb = bus.i_bus_rdata[23:16];
      default: w_lb = bus.i_bus_rdata[31:24];
    endcase
    w_sx = ~r_f3[2];
    if (r_f3[1])
      w_load = bus.i_bus_rdata;
    else if (r_f3[0])
      w_load = {{16{w_sx & w_lh[15]}}, w_lh};
    else
      w_load = {{24{w_sx & w_lb[7]}}, w_lb};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_wen   <= 1'b0;
      r_wmask <= 4'b0000;
      r_done  <= 1'b0;
      r_mis   <= 1'b0;
      r_trap  <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      r_done <= 1'b0;
      r_mis  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (i_valid && !r_done) begin
            r_f3    <= i_funct3;
            r_off   <= i_addr[1:0];
            r_addr  <= {i_addr[31:2], 2'b00};
            r_wen   <= i_mem_write;
            r_wmask <= i_mem_write ? w_wmask : 4'b0000;
            r_wdata <= w_wdata;
            r_trap  <= w_mis;
            if (w_mis) begin
              r_state <= S_DONE;
            end else begin
              r_req   <= 1'b1;
              r_state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (bus.i_bus_ready) begin
            r_req   <= 1'b0;
            r_state <= r_wen ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.i_bus_rvalid) begin
            r_rdata <= w_load;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_mis   <= r_trap;
          if (r_trap)
            r_rdata <= 32'd0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy = ((r_state != S_IDLE) &&
                   (r_state != S_DONE)) ||
                  ((r_state == S_IDLE) && i_valid);

  assign o_done       = r_done;
  assign o_misaligned = r_mis;
  assign o_rdata      = r_rdata;

  assign bus.o_bus_req   = r_req;
  assign bus.o_bus_wen   = r_wen;
  assign bus.o_bus_addr  = r_addr;
  assign bus.o_bus_wmask = r_wmask;
  assign bus.o_bus_wdata = r_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a random-latency bus slave.
// Builds with or without LSU_MISALIGN_TRAP_EN.
module tb_load_store_unit;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        mw;
  logic [2:0]  f3;
  logic [31:0] addr;
  logic [31:0] wd;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        mis;

  lsu_bus_if bus ();

  load_store_unit dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_valid      (valid),
    .i_mem_write  (mw),
    .i_funct3     (f3),
    .i_addr       (addr),
    .i_wdata      (wd),
    .o_busy       (busy),
    .o_done       (done),
    .o_rdata      (rdata),
    .o_misaligned (mis),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } bus_t;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
  } done_t;

  bus_t  bus_q[$];
  done_t done_q[$];

  int passed = 0;
  int total  = 0;

  int          g_rdly  = 0;
  int          g_rvdly = 0;
  bit          g_ovr   = 1'b0;
  logic [31:0] g_ovr_data = 32'd0;
  logic [31:0] m_last  = 32'd0;

  logic [31:0] hs_wdata;
  logic [3:0]  hs_wmask;
  logic [31:0] hs_addr;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h",
                  name, act, exp);
  endtask

  task automatic fail_evt(input string name);
    total++;
    $display("FAIL %s: event not expected", name);
  endtask

  task automatic summary();
    $display("%0d/%0d checks passed", passed, total);
  endtask

  // slave memory content is a fixed hash of the word address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] wa;
    if (g_ovr) return g_ovr_data;
    wa = {2'b00, a[31:2]};
    return (wa * 32'h9E3779B1) ^ 32'hC3A51F0E;
  endfunction

  function automatic int acc_bytes(input logic [2:0] fn);
    if (fn[1]) return 4;
    if (fn[0]) return 2;
    return 1;
  endfunction

  function automatic int acc_off(input logic [2:0] fn,
                                 input logic [31:0] a);
    int n;
    n = acc_bytes(fn);
    if (n == 4) return 0;
    if (n == 2) return 2 * int'(a[1]);
    return int'(a[1:0]);
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] fn,
                                           input logic [31:0] a,
                                           input logic [31:0] w);
    int n;
    int off;
    logic [63:0] v;
    n   = acc_bytes(fn);
    off = acc_off(fn, a);
    v   = ({32'd0, w} >> (8 * off)) & ((64'd1 << (8 * n)) - 64'd1);
    if (!fn[2] && n < 4 && v[8 * n - 1])
      v = v - (64'd1 << (8 * n));
    return v[31:0];
  endfunction

  function automatic logic [3:0] st_mask(input logic [2:0] fn,
                                         input logic [31:0] a);
    int n;
    int m;
    n = acc_bytes(fn);
    m = ((1 << n) - 1) << acc_off(fn, a);
    return m[3:0];
  endfunction

  function automatic logic [31:0] st_data(input logic [2:0] fn,
                                          input logic [31:0] d);
    int n;
    n = acc_bytes(fn);
    if (n == 1) return {24'd0, d[7:0]} * 32'h01010101;
    if (n == 2) return {16'd0, d[15:0]} * 32'h00010001;
    return d;
  endfunction

  function automatic bit is_mis(input logic [2:0] fn,
                                input logic [31:0] a);
    int n;
    n = acc_bytes(fn);
    return TRAP && ((n == 2 && a[0]) ||
                    (n == 4 && a[1:0] != 2'b00));
  endfunction

  // bus slave: drives on the falling edge
  initial begin : slave
    int          rcnt;
    int          vcnt;
    bit          hs;
    bit          hs_load;
    logic [31:0] la;
    rcnt = -1;
    vcnt = -1;
    hs   = 1'b0;
    hs_load = 1'b0;
    la   = 32'd0;
    bus.i_bus_ready  = 1'b0;
    bus.i_bus_rvalid = 1'b0;
    bus.i_bus_rdata  = 32'd0;
    forever begin
      @(negedge clk);
      if (hs) begin
        if (hs_load) vcnt = g_rvdly;
        hs = 1'b0;
      end
      if (vcnt == 0) begin
        bus.i_bus_rvalid = 1'b1;
        bus.i_bus_rdata  = mem_word(la);
        vcnt = -1;
      end else if (vcnt > 0) begin
        bus.i_bus_rvalid = 1'b0;
        bus.i_bus_rdata  = $urandom;
        vcnt--;
      end else begin
        bus.i_bus_rvalid = ($urandom_range(3) == 0);
        bus.i_bus_rdata  = $urandom;
      end
      if (bus.o_bus_req) begin
        if (rcnt < 0) rcnt = g_rdly;
        if (rcnt == 0) begin
          bus.i_bus_ready = 1'b1;
          hs      = 1'b1;
          hs_load = !bus.o_bus_wen;
          la      = bus.o_bus_addr;
          rcnt    = -1;
        end else begin
          bus.i_bus_ready = 1'b0;
          rcnt--;
        end
      end else begin
        bus.i_bus_ready = ($urandom_range(1) == 1);
        rcnt = -1;
      end
    end
  end

  // monitor: samples 2 time units after the falling edge
  initial begin : monitor
    bit   stall;
    bus_t prev;
    bus_t e;
    done_t d;
    stall = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("hold_req", {31'd0, bus.o_bus_req}, 32'd1);
          chk("hold_addr", bus.o_bus_addr, prev.addr);
          chk("hold_wmask", {28'd0, bus.o_bus_wmask},
              {28'd0, prev.wmask});
          chk("hold_wdata", bus.o_bus_wdata, prev.wdata);
          chk("hold_wen", {31'd0, bus.o_bus_wen},
              {31'd0, prev.wen});
        end
        if (bus.o_bus_req)
          chk("busy_in_req", {31'd0, busy}, 32'd1);
        if (bus.o_bus_req && bus.i_bus_ready) begin
          hs_wdata = bus.o_bus_wdata;
          hs_wmask = bus.o_bus_wmask;
          hs_addr  = bus.o_bus_addr;
          if (bus_q.size() == 0) begin
            fail_evt("unexpected_bus_req");
          end else begin
            e = bus_q.pop_front();
            chk("bus_addr", bus.o_bus_addr, e.addr);
            chk("bus_wen", {31'd0, bus.o_bus_wen},
                {31'd0, e.wen});
            chk("bus_wmask", {28'd0, bus.o_bus_wmask},
                {28'd0, e.wmask});
            if (e.wen)
              chk("bus_wdata", bus.o_bus_wdata, e.wdata);
          end
        end
        stall = bus.o_bus_req && !bus.i_bus_ready;
        prev.addr  = bus.o_bus_addr;
        prev.wen   = bus.o_bus_wen;
        prev.wmask = bus.o_bus_wmask;
        prev.wdata = bus.o_bus_wdata;
        if (done) begin
          if (done_q.size() == 0) begin
            fail_evt("unexpected_done");
          end else begin
            d = done_q.pop_front();
            chk("rdata", rdata, d.rdata);
            chk("misaligned", {31'd0, mis}, {31'd0, d.mis});
          end
        end
      end
    end
  end

  task automatic run_op(input bit we,
                        input logic [2:0] fn,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        input int rd,
                        input int rv,
                        output int lat);
    bus_t  be;
    done_t de;
    bit    m;
    g_rdly  = rd;
    g_rvdly = rv;
    m = is_mis(fn, a);
    if (!m) begin
      be.addr  = {a[31:2], 2'b00};
      be.wen   = we;
      be.wmask = we ? st_mask(fn, a) : 4'b0000;
      be.wdata = st_data(fn, d);
      bus_q.push_back(be);
    end
    if (m) m_last = 32'd0;
    else if (!we) m_last = load_val(fn, a, mem_word(a));
    de.rdata = m_last;
    de.mis   = m;
    done_q.push_back(de);
    valid = 1'b1;
    mw    = we;
    f3    = fn;
    addr  = a;
    wd    = d;
    lat   = -1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) begin
      fail_evt("done_timeout");
      summary();
      $finish;
    end
    // valid stays high through the done cycle; no re-accept allowed
    @(negedge clk);
    valid = 1'b0;
  endtask

  initial begin : stim
    int lat;
    rst   = 1'b1;
    valid = 1'b0;
    mw    = 1'b0;
    f3    = 3'd0;
    addr  = 32'd0;
    wd    = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_req", {31'd0, bus.o_bus_req}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_mis", {31'd0, mis}, 32'd0);
    chk("rst_wen", {31'd0, bus.o_bus_wen}, 32'd0);
    chk("rst_wmask", {28'd0, bus.o_bus_wmask}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, lat);
    chk("sw_latency", lat, 3);
    chk("sw_addr", hs_addr, 32'h100);
    chk("sw_wmask", {28'd0, hs_wmask}, 32'hF);

    run_op(1'b1, 3'b000, 32'h103, 32'h000000A5, 0, 0, lat);
    chk("sb_wdata", hs_wdata, 32'hA5A5A5A5);
    chk("sb_wmask", {28'd0, hs_wmask}, 32'h8);

    g_ovr      = 1'b1;
    g_ovr_data = 32'h00008000;
    run_op(1'b0, 3'b000, 32'h201, 32'd0, 0, 0, lat);
    chk("lb_latency", lat, 4);
    chk("lb_value", rdata, 32'hFFFFFF80);
    run_op(1'b0, 3'b100, 32'h201, 32'd0, 1, 1, lat);
    chk("lbu_value", rdata, 32'h00000080);

    g_ovr_data = 32'h87651234;
    run_op(1'b0, 3'b001, 32'h302, 32'd0, 3, 2, lat);
    chk("lh_value", rdata, 32'hFFFF8765);
    chk("lh_wmask", {28'd0, hs_wmask}, 32'h0);
    g_ovr = 1'b0;

    run_op(1'b1, 3'b001, 32'h306, 32'h0000BEEF, 1, 0, lat);
    chk("sh_keeps_rdata", rdata, 32'hFFFF8765);
    chk("sh_wmask", {28'd0, hs_wmask}, 32'hC);

    run_op(1'b0, 3'b010, 32'h102, 32'd0, 0, 0, lat);
    if (TRAP) begin
      chk("trap_latency", lat, 2);
      chk("trap_mis", {31'd0, mis}, 32'd0);
      chk("trap_rdata", rdata, 32'd0);
    end else begin
      chk("lw_unaligned_latency", lat, 4);
      chk("lw_unaligned_value", rdata, mem_word(32'h100));
    end

    // reset while waiting for read data
    g_rdly  = 0;
    g_rvdly = 6;
    begin
      bus_t be;
      be.addr  = 32'h400;
      be.wen   = 1'b0;
      be.wmask = 4'b0000;
      be.wdata = 32'd0;
      bus_q.push_back(be);
    end
    valid = 1'b1;
    mw    = 1'b0;
    f3    = 3'b010;
    addr  = 32'h400;
    @(negedge clk);
    @(negedge clk);
    valid = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    m_last = 32'd0;
    repeat (12) begin
      @(negedge clk);
      chk("rst_wait_req", {31'd0, bus.o_bus_req}, 32'd0);
    end
    chk("rst_wait_rdata", rdata, 32'd0);

    for (int i = 0; i < 300; i++) begin
      run_op(($urandom_range(1) == 1),
             3'($urandom_range(7)),
             $urandom, $urandom,
             $urandom_range(3), $urandom_range(3), lat);
    end

    repeat (4) @(negedge clk);
    chk("bus_q_empty", bus_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    summary();
    $finish;
  end

endmodule
